// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester-side bus of the RAM port arbiter
interface ram_port_arbiter_if #(
    parameter int AW   = 6,
    parameter int DW   = 8,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic               rd_valid;
    logic [DW-1:0]      rd_data;
    logic [1:0]         rd_id;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rd_valid, rd_data, rd_id
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rd_valid, rd_data, rd_id
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter for one synchronous RAM port with clear sweep
module ram_port_arbiter #(
    parameter int AW   = 6,
    parameter int DW   = 8,
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_port_arbiter_if.slave   bus,
    input  logic                init_start,
    output logic                busy,
    output logic                ram_we,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_wdata,
    input  logic [DW-1:0]       ram_q
);
    typedef enum logic {INIT = 1'b0, ARB = 1'b1} state_t;

    localparam logic [AW-1:0] SWEEP_LAST = '1;

    state_t          state, state_next;
    logic [AW-1:0]   sweep, sweep_next;
    logic [1:0]      last_gnt, last_gnt_next;
    logic [1:0]      winner, idx;
    logic            found;
    logic [NREQ-1:0] gnt_c;
    logic            rd_valid_q, rd_valid_next;
    logic [1:0]      rd_id_q, rd_id_next;

    // Search begins just after the previous winner so everyone active is served once per round.
    always_comb begin
        found  = 1'b0;
        winner = last_gnt;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last_gnt + 2'(k);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_next    = state;
        sweep_next    = sweep;
        last_gnt_next = last_gnt;
        gnt_c         = '0;
        busy          = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;
        rd_valid_next = 1'b0;
        rd_id_next    = rd_id_q;
        case (state)
            INIT: begin
                busy       = 1'b1;
                ram_we     = 1'b1;
                ram_addr   = sweep;
                sweep_next = sweep + 1'b1;
                if (sweep == SWEEP_LAST) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (init_start) begin
                    state_next = INIT;
                    sweep_next = '0;
                end else if (found) begin
                    gnt_c[winner] = 1'b1;
                    last_gnt_next = winner;
                    ram_we        = bus.req_we[winner];
                    ram_addr      = bus.req_addr[winner*AW +: AW];
                    ram_wdata     = bus.req_wdata[winner*DW +: DW];
                    if (!bus.req_we[winner]) begin
                        rd_valid_next = 1'b1;
                        rd_id_next    = winner;
                    end
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            sweep      <= '0;
            last_gnt   <= 2'(NREQ - 1);
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            state      <= state_next;
            sweep      <= sweep_next;
            last_gnt   <= last_gnt_next;
            rd_valid_q <= rd_valid_next;
            rd_id_q    <= rd_id_next;
        end
    end

    // ram_q already holds the word addressed in the grant cycle, so only the strobe is piped.
    assign bus.gnt      = gnt_c;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_id    = rd_id_q;
    assign bus.rd_data  = rd_valid_q ? ram_q : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;
    localparam int AW = 6, DW = 8, NREQ = 4, DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_start = 1'b0;
    logic          busy, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_q;
    logic [DW-1:0] mem [DEPTH];

    ram_port_arbiter_if #(.AW(AW), .DW(DW), .NREQ(NREQ)) bus ();

    ram_port_arbiter #(.AW(AW), .DW(DW), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .init_start (init_start),
        .busy       (busy),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    // Synchronous read-before-write RAM
    always @(posedge clk) begin
        ram_q <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_sweep_left;
    int         m_last;
    int         m_rd_id;
    bit         m_pend;
    logic [7:0] m_pend_data;
    logic [7:0] m_mem [DEPTH];

    // Expectations for the current cycle
    logic [3:0] e_gnt;
    logic       e_busy, e_we, e_rdv, e_addr_chk;
    logic [5:0] e_addr;
    logic [7:0] e_wdata, e_rdd;
    logic [1:0] e_rdid;

    task automatic model_reset();
        m_sweep_left = DEPTH;
        m_last       = NREQ - 1;
        m_rd_id      = 0;
        m_pend       = 0;
        m_pend_data  = '0;
    endtask

    function automatic logic [23:0] rand_addrs(input int maxa);
        logic [23:0] a;
        for (int f = 0; f < NREQ; f++) a[f*AW +: AW] = 6'($urandom_range(0, maxa));
        return a;
    endfunction

    // Drive one cycle at the falling edge and advance the reference model
    task automatic cycle(input logic [3:0] r, input logic [3:0] w, input logic [23:0] a,
                         input logic [31:0] d, input logic ini);
        bit found;
        int wi;
        @(negedge clk);
        bus.req = r; bus.req_we = w; bus.req_addr = a; bus.req_wdata = d; init_start = ini;
        #1;
        e_rdv = m_pend; e_rdd = m_pend_data; e_rdid = 2'(m_rd_id);
        e_gnt = '0; e_busy = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_addr_chk = 0;
        m_pend = 0;
        if (m_sweep_left > 0) begin
            e_busy = 1; e_we = 1; e_addr_chk = 1;
            e_addr = 6'(DEPTH - m_sweep_left);
            m_mem[e_addr] = '0;
            m_sweep_left--;
        end else if (ini) begin
            m_sweep_left = DEPTH;
        end else begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                wi = (m_last + k) % NREQ;
                if (!found && r[wi]) begin
                    found = 1;
                    e_gnt = 4'(1 << wi);
                    e_we = w[wi];
                    e_addr = a[wi*AW +: AW];
                    e_wdata = d[wi*DW +: DW];
                    e_addr_chk = 1;
                    if (w[wi]) m_mem[e_addr] = e_wdata;
                    else begin
                        m_pend = 1; m_pend_data = m_mem[e_addr]; m_rd_id = wi;
                    end
                    m_last = wi;
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
        checks++; if (bus.gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
        checks++; if (bus.rd_id !== 2'd0) begin errors++; $display("FAIL reset_rd_id got %0d exp 0", bus.rd_id); end
        checks++; if (ram_addr !== 6'd0 || ram_we !== 1'b1) begin
            errors++; $display("FAIL reset_ram got addr %0d we %b exp addr 0 we 1", ram_addr, ram_we);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(4'hF, 4'h0, rand_addrs(63), $urandom, 1'b0);
            checks++; if (ram_addr !== 6'(i)) begin errors++; $display("FAIL sweep_addr got %0d exp %0d", ram_addr, i); end
            checks++; if (busy !== 1'b1 || bus.gnt !== 4'b0 || ram_we !== 1'b1 || ram_wdata !== 8'h00) begin
                errors++; $display("FAIL sweep_ctrl cycle %0d got busy %b gnt %b we %b wdata %h exp 1 0000 1 00", i, busy, bus.gnt, ram_we, ram_wdata);
            end
        end
        cycle(4'hF, 4'h0, rand_addrs(63), $urandom, 1'b0);
        checks++; if (bus.gnt !== 4'b0001 || busy !== 1'b0) begin
            errors++; $display("FAIL first_grant got gnt %b busy %b exp 0001 0", bus.gnt, busy);
        end
    endtask

    task automatic test_write_read();
        cycle(4'b0001, 4'b0001, 24'd5, 32'h0000_00A5, 1'b0);
        checks++; if (bus.gnt !== 4'b0001 || ram_we !== 1'b1 || ram_addr !== 6'd5 || ram_wdata !== 8'hA5) begin
            errors++; $display("FAIL wr_port got gnt %b we %b addr %0d data %h exp 0001 1 5 a5", bus.gnt, ram_we, ram_addr, ram_wdata);
        end
        cycle(4'b0001, 4'b0000, 24'd5, 32'h0, 1'b0);
        checks++; if (ram_we !== 1'b0 || bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL rd_port got we %b rd_valid %b exp 0 0", ram_we, bus.rd_valid);
        end
        cycle(4'b0000, 4'b0000, 24'd0, 32'h0, 1'b0);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5 || bus.rd_id !== 2'd0) begin
            errors++; $display("FAIL rd_result got valid %b data %h id %0d exp 1 a5 0", bus.rd_valid, bus.rd_data, bus.rd_id);
        end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL idle_we got %b exp 0", ram_we); end
    endtask

    task automatic test_round_robin();
        cycle(4'b1000, 4'b0000, rand_addrs(63), $urandom, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, 4'b0000, rand_addrs(63), $urandom, 1'b0);
            checks++; if (bus.gnt !== 4'(1 << (i % 4))) begin
                errors++; $display("FAIL rr_all step %0d got %b exp %b", i, bus.gnt, 4'(1 << (i % 4)));
            end
        end
    endtask

    task automatic test_alternate();
        logic [3:0] exp_g;
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1010, 4'($urandom), rand_addrs(63), $urandom, 1'b0);
            exp_g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            checks++; if (bus.gnt !== exp_g) begin
                errors++; $display("FAIL rr_alt step %0d got %b exp %b", i, bus.gnt, exp_g);
            end
        end
    endtask

    task automatic test_init_restart();
        logic [5:0] ad;
        cycle(4'b0010, 4'b0000, rand_addrs(63), $urandom, 1'b1);
        checks++; if (bus.gnt !== 4'b0) begin errors++; $display("FAIL init_no_grant got %b exp 0000", bus.gnt); end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(4'b0010, 4'b0000, rand_addrs(63), $urandom, (i == 10));
            checks++; if (bus.gnt !== 4'b0 || busy !== 1'b1 || ram_addr !== 6'(i)) begin
                errors++; $display("FAIL init_sweep cycle %0d got gnt %b busy %b addr %0d exp 0000 1 %0d", i, bus.gnt, busy, ram_addr, i);
            end
        end
        for (int j = 0; j < 7; j++) begin
            ad = (j == 0) ? 6'd5 : 6'($urandom_range(0, 63));
            cycle((j < 6) ? 4'b0010 : 4'b0000, 4'b0000, {12'd0, ad, 6'd0}, 32'h0, 1'b0);
            if (j > 0) begin
                checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h00 || bus.rd_id !== 2'd1) begin
                    errors++; $display("FAIL cleared_read %0d got valid %b data %h id %0d exp 1 00 1", j, bus.rd_valid, bus.rd_data, bus.rd_id);
                end
            end
        end
    endtask

    task automatic test_read_into_init();
        cycle(4'b0100, 4'b0100, {6'd0, 6'd33, 12'd0}, 32'h003C_0000, 1'b0);
        cycle(4'b0100, 4'b0000, {6'd0, 6'd33, 12'd0}, 32'h0, 1'b0);
        cycle(4'b0010, 4'b0000, rand_addrs(63), 32'h0, 1'b1);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C || bus.rd_id !== 2'd2 || bus.gnt !== 4'b0) begin
            errors++; $display("FAIL read_into_init got valid %b data %h id %0d gnt %b exp 1 3c 2 0000", bus.rd_valid, bus.rd_data, bus.rd_id, bus.gnt);
        end
        cycle(4'b0000, 4'b0000, 24'd0, 32'h0, 1'b0);
        checks++; if (bus.rd_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL init_after_read got valid %b busy %b exp 0 1", bus.rd_valid, busy);
        end
        while (m_sweep_left > 0) cycle(4'b0000, 4'b0000, 24'd0, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle(4'($urandom), 4'($urandom), rand_addrs(7), $urandom, ($urandom_range(0, 99) == 0));
            checks++; if (bus.gnt !== e_gnt || busy !== e_busy || ram_we !== e_we) begin
                errors++; $display("FAIL rand_ctrl %0d got gnt %b busy %b we %b exp %b %b %b", n, bus.gnt, busy, ram_we, e_gnt, e_busy, e_we);
            end
            if (e_addr_chk) begin
                checks++; if (ram_addr !== e_addr || ram_wdata !== e_wdata) begin
                    errors++; $display("FAIL rand_port %0d got addr %0d data %h exp %0d %h", n, ram_addr, ram_wdata, e_addr, e_wdata);
                end
            end
            checks++; if (bus.rd_valid !== e_rdv) begin
                errors++; $display("FAIL rand_rd_valid %0d got %b exp %b", n, bus.rd_valid, e_rdv);
            end
            if (e_rdv) begin
                checks++; if (bus.rd_data !== e_rdd || bus.rd_id !== e_rdid) begin
                    errors++; $display("FAIL rand_rd_data %0d got %h id %0d exp %h id %0d", n, bus.rd_data, bus.rd_id, e_rdd, e_rdid);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        while (m_sweep_left > 0) cycle(4'b0000, 4'b0000, 24'd0, 32'h0, 1'b0);
        cycle(4'b0001, 4'b0000, rand_addrs(63), 32'h0, 1'b0);
        @(negedge clk); #1 rst_n = 1'b0; #1;
        checks++; if (bus.rd_valid !== 1'b0 || busy !== 1'b1 || bus.gnt !== 4'b0) begin
            errors++; $display("FAIL abort_read got valid %b busy %b gnt %b exp 0 1 0000", bus.rd_valid, busy, bus.gnt);
        end
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i <= 20; i++) cycle(4'b0000, 4'b0000, 24'd0, 32'h0, 1'b0);
        checks++; if (ram_addr !== 6'd20) begin errors++; $display("FAIL pre_abort_addr got %0d exp 20", ram_addr); end
        #1 rst_n = 1'b0; #1;
        checks++; if (ram_addr !== 6'd0 || busy !== 1'b1 || ram_we !== 1'b1 || bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL abort_sweep got addr %0d busy %b we %b valid %b exp 0 1 1 0", ram_addr, busy, ram_we, bus.rd_valid);
        end
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(4'hF, 4'h0, rand_addrs(63), $urandom, 1'b0);
            checks++; if (ram_addr !== 6'(i) || bus.gnt !== 4'b0) begin
                errors++; $display("FAIL resweep cycle %0d got addr %0d gnt %b exp %0d 0000", i, ram_addr, bus.gnt, i);
            end
        end
        cycle(4'hF, 4'h0, rand_addrs(63), $urandom, 1'b0);
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL resweep_grant got %b exp 0001", bus.gnt); end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sweep();
        test_write_read();
        test_round_robin();
        test_alternate();
        test_init_restart();
        test_read_into_init();
        test_random();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
